// File: rtl/wb_retire_stage_pkg.sv
// ============================================================================
// Module      : wb_retire_stage_pkg
// Description : Shared types and constants for the writeback/retire stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_retire_stage_pkg;

    localparam int c_ecode_w = 6;

    localparam logic [c_ecode_w-1:0] c_ecode_int = 6'h00;
    localparam logic [c_ecode_w-1:0] c_ecode_ade = 6'h08;
    localparam logic [c_ecode_w-1:0] c_ecode_ale = 6'h09;
    localparam logic [c_ecode_w-1:0] c_ecode_sys = 6'h0B;
    localparam logic [c_ecode_w-1:0] c_ecode_brk = 6'h0C;
    localparam logic [c_ecode_w-1:0] c_ecode_ine = 6'h0D;

    // Width-independent part of a retire entry; the full entry adds pc/result/dest.
    typedef struct packed {
        logic                 gr_we;
        logic                 excp;
        logic [c_ecode_w-1:0] ecode;
    } retire_ctrl_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_retire_queue.sv
// ============================================================================
// Module      : wb_retire_queue
// Description : In-order retire FIFO with youngest-match forwarding search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_retire_queue
    import wb_retire_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [DATA_W-1:0]  push_result,
    input  logic [RADDR_W-1:0] push_dest,
    input  retire_ctrl_t       push_ctrl,
    input  logic               pop,
    input  logic               clear,
    output logic               head_valid,
    output logic [PC_W-1:0]    head_pc,
    output logic [DATA_W-1:0]  head_result,
    output logic [RADDR_W-1:0] head_dest,
    output retire_ctrl_t       head_ctrl,
    output logic               full,
    input  logic [RADDR_W-1:0] lookup_addr,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data
);

    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  result;
        logic [RADDR_W-1:0] dest;
        retire_ctrl_t       ctrl;
    } retire_entry_t;

    retire_entry_t      r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;
    logic [DEPTH-1:0]   w_match;

    assign w_empty    = (r_count == '0);
    assign full       = (r_count == c_depth);
    assign head_valid = !w_empty;
    assign w_do_push  = push && !full;
    assign w_do_pop   = pop && !w_empty;

    // Clear wins over a same-cycle push: the flushing cycle must not admit new work.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && w_do_push) begin
            r_mem[r_tail] <= {push_pc, push_result, push_dest, push_ctrl};
        end
    end

    assign head_pc     = r_mem[r_head].pc;
    assign head_result = r_mem[r_head].result;
    assign head_dest   = r_mem[r_head].dest;
    assign head_ctrl   = r_mem[r_head].ctrl;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign w_match[i] = r_mem[i].ctrl.gr_we && !r_mem[i].ctrl.excp &&
                            (r_mem[i].dest == lookup_addr) && (lookup_addr != '0);
    end

    // Walk oldest to youngest so a later (younger) hit overrides an older one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((c_ptr_w + 1)'(k) < r_count) && w_match[r_head + c_ptr_w'(k)]) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem[r_head + c_ptr_w'(k)].result;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_retire_stage.sv
// ============================================================================
// Module      : wb_retire_stage
// Description : Writeback/retire stage: in-order retire to the RF, forwarding,
//               exception-to-flush conversion. Optional WB_PERF_CNT_EN adds a
//               64-bit retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [PC_W-1:0]      ms_pc,
    input  logic [DATA_W-1:0]    ms_result,
    input  logic [RADDR_W-1:0]   ms_dest,
    input  logic                 ms_gr_we,
    input  logic                 ms_excp,
    input  logic [c_ecode_w-1:0] ms_ecode,
    input  logic                 rf_ready,
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    input  logic [RADDR_W-1:0]   ds_raddr,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 ws_flush,
    output logic [PC_W-1:0]      ws_flush_pc,
    output logic [c_ecode_w-1:0] ws_flush_ecode,
    output logic [PC_W-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [RADDR_W-1:0]   debug_wb_rf_wnum,
    output logic [DATA_W-1:0]    debug_wb_rf_wdata,
    output logic [63:0]          perf_retired
);

    logic               w_head_valid;
    logic [PC_W-1:0]    w_head_pc;
    logic [DATA_W-1:0]  w_head_result;
    logic [RADDR_W-1:0] w_head_dest;
    retire_ctrl_t       w_head_ctrl;
    retire_ctrl_t       w_push_ctrl;
    logic               w_full;
    logic               w_push;
    logic               w_retire;
    logic               w_flush_req;

    wb_state_t          r_state;
    wb_state_t          w_state_nxt;

    assign w_push_ctrl = '{gr_we: ms_gr_we, excp: ms_excp, ecode: ms_ecode};
    assign w_push      = ms_to_ws_valid && ws_allowin;

    // Excepting or non-writing heads never wait for the RF port.
    assign w_retire    = w_head_valid && (r_state == ST_RUN) &&
                         (w_head_ctrl.excp || !w_head_ctrl.gr_we || rf_ready);
    assign w_flush_req = w_retire && w_head_ctrl.excp;

    wb_retire_queue #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push        (w_push),
        .push_pc     (ms_pc),
        .push_result (ms_result),
        .push_dest   (ms_dest),
        .push_ctrl   (w_push_ctrl),
        .pop         (w_retire),
        .clear       (w_flush_req),
        .head_valid  (w_head_valid),
        .head_pc     (w_head_pc),
        .head_result (w_head_result),
        .head_dest   (w_head_dest),
        .head_ctrl   (w_head_ctrl),
        .full        (w_full),
        .lookup_addr (ds_raddr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ws_allowin depends only on registered state so rf_ready never reaches it.
    always_comb begin
        w_state_nxt    = r_state;
        ws_allowin     = 1'b0;
        ws_flush       = 1'b0;
        ws_flush_pc    = '0;
        ws_flush_ecode = '0;
        case (r_state)
            ST_RUN: begin
                ws_allowin = !w_full;
                if (w_flush_req) begin
                    w_state_nxt    = ST_FLUSH;
                    ws_flush       = 1'b1;
                    ws_flush_pc    = w_head_pc;
                    ws_flush_ecode = w_head_ctrl.ecode;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign rf_we    = w_retire && w_head_ctrl.gr_we && !w_head_ctrl.excp;
    assign rf_waddr = w_head_valid ? w_head_dest : '0;
    assign rf_wdata = w_head_valid ? w_head_result : '0;

    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_pc       = w_retire ? w_head_pc : '0;
    assign debug_wb_rf_wnum  = w_retire ? w_head_dest : '0;
    assign debug_wb_rf_wdata = w_retire ? w_head_result : '0;

`ifdef WB_PERF_CNT_EN
    logic [63:0] r_perf_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_retired <= 64'd0;
        end else if (w_retire) begin
            r_perf_retired <= r_perf_retired + 64'd1;
        end
    end

    assign perf_retired = r_perf_retired;
`else
    assign perf_retired = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
// ============================================================================
// Module      : tb_wb_retire_stage
// Description : Directed vector bench for wb_retire_stage (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_retire_stage;

`ifdef WB_PERF_CNT_EN
    localparam logic c_perf_on = 1'b1;
`else
    localparam logic c_perf_on = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_excp;
    logic [5:0]  ms_ecode;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ds_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        ws_flush;
    logic [31:0] ws_flush_pc;
    logic [5:0]  ws_flush_ecode;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [63:0] perf_retired;

    int checks;
    int failures;
    int flush_cnt;

    wb_retire_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_result         (ms_result),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_excp           (ms_excp),
        .ms_ecode          (ms_ecode),
        .rf_ready          (rf_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ds_raddr          (ds_raddr),
        .fwd_hit           (fwd_hit),
        .fwd_data          (fwd_data),
        .ws_flush          (ws_flush),
        .ws_flush_pc       (ws_flush_pc),
        .ws_flush_ecode    (ws_flush_ecode),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .perf_retired      (perf_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vl;
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  dst;
        logic        gw;
        logic        ex;
        logic [5:0]  ec;
        logic        rr;
        logic [4:0]  ds;
        logic        e_allow;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_hit;
        logic [31:0] e_fdata;
        logic        e_flush;
        logic [31:0] e_fpc;
        logic [5:0]  e_fec;
        logic [31:0] e_dpc;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(
        input logic vl, input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dst,
        input logic gw, input logic ex, input logic [5:0] ec, input logic rr, input logic [4:0] ds,
        input logic a, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic h, input logic [31:0] fd, input logic fl, input logic [31:0] fpc,
        input logic [5:0] fec, input logic [31:0] dpc);
        vec_t r;
        r.vl = vl; r.pc = pc; r.res = res; r.dst = dst; r.gw = gw; r.ex = ex; r.ec = ec;
        r.rr = rr; r.ds = ds; r.e_allow = a; r.e_we = we; r.e_waddr = wa; r.e_wdata = wd;
        r.e_hit = h; r.e_fdata = fd; r.e_flush = fl; r.e_fpc = fpc; r.e_fec = fec; r.e_dpc = dpc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vl, input logic [31:0] pc, input logic [31:0] res,
                         input logic [4:0] dst, input logic gw, input logic ex,
                         input logic [5:0] ec, input logic rr, input logic [4:0] ds);
        ms_to_ws_valid = vl; ms_pc = pc; ms_result = res; ms_dest = dst;
        ms_gr_we = gw; ms_excp = ex; ms_ecode = ec; rf_ready = rr; ds_raddr = ds;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        flush_cnt = 0;
        reset     = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b0, 5'd0);

        //            vl pc            res       dst  gw ex ec     rr ds   | allow we wa    wdata     hit fdata     fl fpc           fec    dbg_pc
        vt[0]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[1]  = mk(1, 32'h1c000000, 32'hDEAD, 5'd5, 1, 0, 6'h00, 1, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[2]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd5,  1, 1, 5'd5, 32'hDEAD, 1, 32'hDEAD, 0, 32'h0,        6'h00, 32'h1c000000);
        vt[3]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[4]  = mk(1, 32'h1c000004, 32'h11,   5'd1, 1, 0, 6'h00, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[5]  = mk(1, 32'h1c000008, 32'h22,   5'd2, 1, 0, 6'h00, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[6]  = mk(1, 32'h1c00000c, 32'h77,   5'd7, 1, 0, 6'h00, 0, 5'd0,  0, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[7]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd0,  0, 1, 5'd1, 32'h11,   0, 32'h0,    0, 32'h0,        6'h00, 32'h1c000004);
        vt[8]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd0,  1, 1, 5'd2, 32'h22,   0, 32'h0,    0, 32'h0,        6'h00, 32'h1c000008);
        vt[9]  = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd7,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[10] = mk(1, 32'h1c000030, 32'h1,    5'd3, 1, 0, 6'h00, 0, 5'd3,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[11] = mk(1, 32'h1c000034, 32'h2,    5'd3, 1, 0, 6'h00, 0, 5'd3,  1, 0, 5'd0, 32'h0,    1, 32'h1,    0, 32'h0,        6'h00, 32'h0);
        vt[12] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd3,  0, 0, 5'd0, 32'h0,    1, 32'h2,    0, 32'h0,        6'h00, 32'h0);
        vt[13] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd0,  0, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[14] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd4,  0, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[15] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd3,  0, 1, 5'd3, 32'h1,    1, 32'h2,    0, 32'h0,        6'h00, 32'h1c000030);
        vt[16] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd3,  1, 1, 5'd3, 32'h2,    1, 32'h2,    0, 32'h0,        6'h00, 32'h1c000034);
        vt[17] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd3,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[18] = mk(1, 32'h1c000010, 32'h66,   5'd6, 1, 1, 6'h0B, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[19] = mk(1, 32'h1c000014, 32'h88,   5'd8, 1, 0, 6'h00, 1, 5'd6,  1, 0, 5'd0, 32'h0,    0, 32'h0,    1, 32'h1c000010, 6'h0B, 32'h1c000010);
        vt[20] = mk(1, 32'h1c000014, 32'h88,   5'd8, 1, 0, 6'h00, 1, 5'd8,  0, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[21] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 1, 5'd8,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[22] = mk(1, 32'h1c000020, 32'h99,   5'd9, 0, 0, 6'h00, 0, 5'd9,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);
        vt[23] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd9,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h1c000020);
        vt[24] = mk(0, 32'h0,        32'h0,    5'd0, 0, 0, 6'h00, 0, 5'd0,  1, 0, 5'd0, 32'h0,    0, 32'h0,    0, 32'h0,        6'h00, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_allowin", 64'(ws_allowin), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_flush", 64'(ws_flush), 64'd0);
        chk("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
        chk("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_perf", perf_retired, 64'd0);
        next_cycle();

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].vl, vt[i].pc, vt[i].res, vt[i].dst, vt[i].gw, vt[i].ex, vt[i].ec,
                  vt[i].rr, vt[i].ds);
            @(negedge clk);
            chk($sformatf("v%0d_allowin", i), 64'(ws_allowin), 64'(vt[i].e_allow));
            chk($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vt[i].e_we));
            chk($sformatf("v%0d_dbg_we", i), 64'(debug_wb_rf_we), 64'({4{vt[i].e_we}}));
            if (vt[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(vt[i].e_waddr));
                chk($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vt[i].e_wdata));
                chk($sformatf("v%0d_dbg_wnum", i), 64'(debug_wb_rf_wnum), 64'(vt[i].e_waddr));
                chk($sformatf("v%0d_dbg_wdata", i), 64'(debug_wb_rf_wdata), 64'(vt[i].e_wdata));
            end
            chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'(vt[i].e_hit));
            if (vt[i].e_hit) begin
                chk($sformatf("v%0d_fwd_data", i), 64'(fwd_data), 64'(vt[i].e_fdata));
            end
            chk($sformatf("v%0d_flush", i), 64'(ws_flush), 64'(vt[i].e_flush));
            if (vt[i].e_flush) begin
                chk($sformatf("v%0d_flush_pc", i), 64'(ws_flush_pc), 64'(vt[i].e_fpc));
                chk($sformatf("v%0d_flush_ecode", i), 64'(ws_flush_ecode), 64'(vt[i].e_fec));
            end
            chk($sformatf("v%0d_dbg_pc", i), 64'(debug_wb_pc), 64'(vt[i].e_dpc));
            next_cycle();
        end

        // Streaming: 9 normal retires then one exception, one entry per cycle
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b0, 5'd0);
        next_cycle();
        reset = 1'b0;
        for (int n = 0; n < 13; n++) begin
            if (n < 10) begin
                drive(1'b1, 32'h1c000100 + 32'(4 * n), 32'(n + 100), 5'(n + 1), 1'b1,
                      (n == 9), (n == 9) ? 6'h0B : 6'h00, 1'b1, 5'd0);
            end else begin
                drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b1, 5'd0);
            end
            @(negedge clk);
            if (ws_flush) flush_cnt++;
            next_cycle();
        end
        @(negedge clk);
        chk("stream_flush_count", 64'(flush_cnt), 64'd1);
        chk("stream_perf", perf_retired, c_perf_on ? 64'd10 : 64'd0);
        chk("stream_allowin", 64'(ws_allowin), 64'd1);
        next_cycle();

        // Reset with an entry still buffered
        drive(1'b1, 32'h1c000200, 32'h55, 5'd4, 1'b1, 1'b0, 6'h0, 1'b0, 5'd0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b0, 5'd0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b1, 5'd4);
        @(negedge clk);
        chk("midrst_perf", perf_retired, 64'd0);
        chk("midrst_rf_we", 64'(rf_we), 64'd0);
        chk("midrst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("midrst_allowin", 64'(ws_allowin), 64'd1);
        next_cycle();

        // Counter restarts from zero after reset
        drive(1'b1, 32'h1c000300, 32'h66, 5'd6, 1'b1, 1'b0, 6'h0, 1'b1, 5'd0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h0, 1'b1, 5'd0);
        @(negedge clk);
        chk("post_rst_rf_we", 64'(rf_we), 64'd1);
        chk("post_rst_waddr", 64'(rf_waddr), 64'd6);
        next_cycle();
        @(negedge clk);
        chk("post_rst_perf", perf_retired, c_perf_on ? 64'd1 : 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
